// File: rtl/binary_mux_n_pipe_if.sv
// rtl/binary_mux_n_pipe_if.sv - channel, select and output handshake bundle for binary_mux_n_pipe
interface binary_mux_n_pipe_if #(
    parameter int K = 1,
    parameter int N = 3,
    parameter int S = 2
);
    logic [N*K-1:0] a;
    logic [N-1:0]   a_valid;
    logic [N-1:0]   a_ready;
    logic [S-1:0]   sb;
    logic           sb_ld;
    logic [S-1:0]   sel_q;
    logic           sel_err;
    logic [K-1:0]   b;
    logic           b_valid;
    logic           b_ready;

    modport master (
        output a, a_valid, sb, sb_ld, b_ready,
        input  a_ready, sel_q, sel_err, b, b_valid
    );

    modport slave (
        input  a, a_valid, sb, sb_ld, b_ready,
        output a_ready, sel_q, sel_err, b, b_valid
    );
endinterface

// File: rtl/binary_mux_n_pipe.sv
// rtl/binary_mux_n_pipe.sv - N-channel select mux with one-entry registered output stage
// Optional build macro: BINARY_MUX_XFILL_EN drives b to X while the output stage is empty.
module binary_mux_n_pipe #(
    parameter int K = 1,
    parameter int N = 3,
    parameter int S = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    binary_mux_n_pipe_if.slave    bus
);
    logic [S-1:0] sel_cur_q, sel_cur_d;
    logic         sel_err_q, sel_err_d;
    logic [K-1:0] b_data_q, b_data_d;
    logic         b_valid_q, b_valid_d;

    logic [K-1:0] a_sel;
    logic         a_sel_valid;
    logic         out_free;
    logic         accept;
    logic         sb_in_range;

    always_comb begin
        a_sel       = '0;
        a_sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sel_cur_q == S'(i)) begin
                a_sel       = bus.a[i*K +: K];
                a_sel_valid = bus.a_valid[i];
            end
        end
    end

    assign out_free    = ~b_valid_q | bus.b_ready;
    assign accept      = a_sel_valid & out_free;
    assign sb_in_range = (32'(bus.sb) < N);

    always_comb begin
        bus.a_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.a_ready[i] = (sel_cur_q == S'(i)) & out_free;
        end
    end

    // The transfer always uses the select held this cycle; a new select lands next cycle.
    always_comb begin
        sel_cur_d = sel_cur_q;
        sel_err_d = sel_err_q;
        b_data_d  = b_data_q;
        b_valid_d = b_valid_q;
        if (bus.sb_ld) begin
            if (sb_in_range) begin
                sel_cur_d = bus.sb;
            end else begin
                sel_err_d = 1'b1;
            end
        end
        if (accept) begin
            b_data_d  = a_sel;
            b_valid_d = 1'b1;
        end else if (b_valid_q && bus.b_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_cur_q <= '0;
            sel_err_q <= 1'b0;
            b_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            sel_cur_q <= sel_cur_d;
            sel_err_q <= sel_err_d;
            b_data_q  <= b_data_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign bus.sel_q   = sel_cur_q;
    assign bus.sel_err = sel_err_q;
    assign bus.b_valid = b_valid_q;
`ifdef BINARY_MUX_XFILL_EN
    assign bus.b = b_valid_q ? b_data_q : {K{1'bx}};
`else
    assign bus.b = b_data_q;
`endif
endmodule

// File: tb/tb_binary_mux_n_pipe.sv
// tb/tb_binary_mux_n_pipe.sv - scoreboard bench for binary_mux_n_pipe with K=8, N=3, S=2
module tb_binary_mux_n_pipe;
    localparam int K = 8;
    localparam int N = 3;
    localparam int S = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    binary_mux_n_pipe_if #(.K(K), .N(N), .S(S)) bif ();

    binary_mux_n_pipe #(.K(K), .N(N), .S(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: selected channel, sticky error, words in flight, last loaded word.
    logic [K-1:0] exp_q[$];
    int           m_sel;
    bit           m_err;
    logic [K-1:0] m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bif.b_valid === 1'b1 && bif.b_ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL drain_underflow: got word %0h expected none at %0t", bif.b, $time);
            end else begin
                logic [K-1:0] e;
                e = exp_q.pop_front();
                if (bif.b !== e) begin
                    n_fail++;
                    $display("FAIL drain_data: got %0h expected %0h at %0t", bif.b, e, $time);
                end
            end
        end
    end

    task automatic cycle(input logic rst_v, input logic [N*K-1:0] a_v, input logic [N-1:0] av_v,
                         input logic [S-1:0] sb_v, input logic ld_v, input logic br_v);
        bit           full;
        logic [N-1:0] exp_rdy;
        logic [K-1:0] chan;
        @(posedge clk);
        #2;
        rst         = rst_v;
        bif.a       = a_v;
        bif.a_valid = av_v;
        bif.sb      = sb_v;
        bif.sb_ld   = ld_v;
        bif.b_ready = br_v;
        #1;
        full    = (exp_q.size() != 0);
        exp_rdy = (!full || br_v) ? N'(1 << m_sel) : '0;
        chk("a_ready", 32'(bif.a_ready), 32'(exp_rdy));
        chk("sel_q", 32'(bif.sel_q), 32'(m_sel));
        chk("sel_err", 32'(bif.sel_err), 32'(m_err));
        chk("b_valid", 32'(bif.b_valid), 32'(full));
        if (full) begin
            chk("b_held", 32'(bif.b), 32'(exp_q[0]));
        end else begin
`ifndef BINARY_MUX_XFILL_EN
            chk("b_idle", 32'(bif.b), 32'(m_last));
`endif
        end
        if (rst_v) begin
            @(posedge clk);
            exp_q.delete();
            m_sel  = 0;
            m_err  = 0;
            m_last = '0;
        end else begin
            chan = a_v[m_sel*K +: K];
            if (av_v[m_sel] && (!full || br_v)) begin
                exp_q.push_back(chan);
                m_last = chan;
            end
            if (ld_v) begin
                if (int'(sb_v) < N) m_sel = int'(sb_v);
                else m_err = 1;
            end
        end
    endtask

    function automatic logic [N*K-1:0] rand_a();
        logic [N*K-1:0] r;
        r = {$urandom, $urandom};
        return r;
    endfunction

    initial begin
        logic [N*K-1:0] av;
        n_tests = 0;
        n_fail  = 0;
        m_sel   = 0;
        m_err   = 0;
        m_last  = '0;
        rst         = 1'b1;
        bif.a       = '0;
        bif.a_valid = '0;
        bif.sb      = '0;
        bif.sb_ld   = 1'b0;
        bif.b_ready = 1'b0;

        cycle(1, '0, '0, 0, 0, 0);
        cycle(1, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 0);

        cycle(0, '0, '0, 2, 1, 1);
        av = '0;
        av[2*K +: K] = 8'hA5;
        cycle(0, av, 3'b100, 0, 0, 1);
        cycle(0, '0, '0, 0, 0, 0);
        chk("a5_word", 32'(bif.b), 32'h00A5);

        cycle(0, '0, '0, 3, 1, 0);
        cycle(0, '0, '0, 0, 0, 0);
        cycle(0, '0, '0, 0, 0, 1);

        for (int i = 0; i < 5; i++) cycle(0, rand_a(), 3'b100, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, rand_a(), 3'b100, 0, 0, 1);

        cycle(0, '0, '0, 0, 1, 1);
        cycle(0, '0, '0, 0, 0, 1);
        av = rand_a();
        av[0 +: K] = 8'h11;
        cycle(0, av, 3'b001, 1, 1, 1);
        av = rand_a();
        av[K +: K] = 8'h22;
        cycle(0, av, 3'b011, 0, 0, 1);
        cycle(0, '0, '0, 0, 0, 1);

        for (int i = 0; i < 10; i++) cycle(0, rand_a(), 3'b111, 0, 0, 1'($urandom));

        cycle(0, rand_a(), 3'b010, 0, 0, 0);
        cycle(1, rand_a(), 3'b111, 2, 1, 0);
        cycle(0, '0, '0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0), rand_a(), 3'($urandom), 2'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 0, 1);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/binary_mux_n_pipe.md
BINARY_MUX_N_PIPE -- requirements
Module: binary_mux_n_pipe

Interface
REQ-001 SHALL have parameter K, default 1, data width in bits (K >= 1).
REQ-002 SHALL have parameter N, default 3, number of input channels (2 <= N <= 16).
REQ-003 SHALL have parameter S, default 2, select width in bits (2^S >= N).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port a  input  N*K  packed channel data; channel i occupies bits [i*K+K-1 : i*K].
REQ-007 SHALL have port a_valid  input  N  per-channel data valid.
REQ-008 SHALL have port a_ready  output  N  per-channel ready.
REQ-009 SHALL have port sb  input  S  binary-coded select value.
REQ-010 SHALL have port sb_ld  input  1  select-load strobe.
REQ-011 SHALL have port sel_q  output  S  currently active select.
REQ-012 SHALL have port sel_err  output  1  sticky out-of-range-select flag.
REQ-013 SHALL have port b  output  K  registered output data.
REQ-014 SHALL have port b_valid  output  1  output data valid.
REQ-015 SHALL have port b_ready  input  1  downstream ready.

Function
REQ-016 SHALL latch sb into sel_q on a cycle with sb_ld=1 and sb < N; the new select takes effect from the next cycle.
REQ-017 SHALL hold sel_q and set sel_err=1 on a cycle with sb_ld=1 and sb >= N; sel_err stays set until rst.
REQ-018 SHALL hold the output stage as a one-entry register: full when b_valid=1, empty when b_valid=0.
REQ-019 SHALL drive a_ready[sel_q] = (~b_valid | b_ready), and a_ready[j]=0 for every j != sel_q.
REQ-020 SHALL accept channel sel_q when a_valid[sel_q] & a_ready[sel_q]; b <= a[sel_q], b_valid <= 1 on the next edge (latency 1 cycle).
REQ-021 SHALL clear b_valid when b_valid & b_ready and no accept occurs in the same cycle.
REQ-022 SHALL, with simultaneous drain and accept, keep b_valid=1 and load new data (full throughput, one word per cycle).
REQ-023 SHALL hold b and b_valid unchanged while b_valid=1 and b_ready=0 (no data loss, no overwrite).
REQ-024 SHALL, when sb_ld and an accept coincide, transfer from the old sel_q; the new select applies only to later transfers.
REQ-025 SHALL leave the output register untouched by a select change: a word already in b is delivered regardless of later sb_ld.
REQ-026 SHALL ignore a_valid on non-selected channels (no accept, no side effect).

Reset
REQ-027 SHALL, on rst=1 at a rising edge, set sel_q=0, sel_err=0, b_valid=0, b=0 (in the non-X-fill build; see REQ-029); rst has priority over sb_ld and all handshakes.
REQ-028 SHALL, on rst asserted mid-transfer, discard the held output word; a_ready reflects post-reset state (a_ready[0]=1) from the first cycle after reset.

Configuration
REQ-029 SHALL, when macro BINARY_MUX_XFILL_EN is defined, drive b to {K{1'bx}} whenever b_valid=0 (including after reset and after drain); without it, b holds the last delivered word (0 after reset).
REQ-030 SHALL keep handshake, select and sel_err behaviour identical in both builds.

Verification
REQ-031 SHALL cover: K=8,N=3; rst, then sb=2,sb_ld=1, a_valid[2]=1,a[2]=8'hA5, b_ready=1 -> sel_q=2 next cycle, b=8'hA5,b_valid=1 one cycle after accept.
REQ-032 SHALL cover: sb=3 with sb_ld=1 (N=3) -> sel_err=1, sel_q unchanged; sel_err stays 1 until rst.
REQ-033 SHALL cover: b_ready=0 for 4 cycles with b_valid=1, a_valid[sel_q]=1 -> a_ready[sel_q]=0, b stable; b_ready=1 -> one word per cycle thereafter.
REQ-034 SHALL cover: sb_ld (0->1) in the same cycle as an accept on channel 0 with a[0]=8'h11 -> b=8'h11; next transfer from channel 1.
REQ-035 SHALL cover: rst asserted while b_valid=1,b_ready=0 -> b_valid=0, sel_q=0, b=0 (or X with BINARY_MUX_XFILL_EN) next cycle.
REQ-036 SHALL cover: a_valid on all channels with sel_q=1 for 10 cycles -> only channel-1 data appears on b; a_ready[0]=a_ready[2]=0 throughout.
